// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALU_op codes, mux selects and the control-word layout.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDIU) || (op == OP_ORI) ||
           (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational control-word decode from the current state and opcode.
// Only FETCH and BRANCH look past the state, at mem_ready and zero.
module multi_cycle_ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.illegal   = !op_legal(op_i);
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_WB_I: ctrl_o.reg_write = 1'b1;
      S_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.i_or_d  = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.i_or_d  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PC_TARGET;
        ctrl_o.pc_write  = zero_i;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: state register, opcode
// latch and next-state logic; the control word comes from the decode block.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALU_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  logic [5:0] dec_op;
  ctrl_t      ctrl_raw, ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDIU, OP_ORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
    end
  end

  // DECODE sees the live opcode; later states use the copy latched at its end.
  assign dec_op = (state_q == S_DECODE) ? opcode : opcode_q;

  multi_cycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (dec_op),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // Reset blanks the whole control word combinationally so an aborted
  // memory access or write is withdrawn in the same cycle.
  assign ctrl  = rst ? '0 : ctrl_raw;
  assign state = rst ? 4'd0 : state_q;

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign i_or_d     = ctrl.i_or_d;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign ALU_op     = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: each instruction is expanded into its expected
// per-cycle control words and stimulus, then replayed against the DUT.
module tb_multi_cycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, ALU_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ALU_op(ALU_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          rst;
    bit          rdy;
    bit          z;
    bit   [5:0]  opc;
    logic [19:0] exp;
  } cyc_t;

  cyc_t q[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic logic [19:0] ow(input logic [3:0] st, input logic req, we, iord,
                                     irw, pcw, input logic [1:0] pcs, input logic a,
                                     input logic [1:0] b, op, input logic rw, rd, m2r, ill);
    return {req, we, iord, irw, pcw, pcs, a, b, op, rw, rd, m2r, ill, st};
  endfunction

  // Don't-care inputs get random values to show they are ignored.
  function automatic cyc_t dc(input logic [19:0] e);
    cyc_t x;
    x.rst = 1'b0;
    x.rdy = 1'($urandom);
    x.z   = 1'($urandom);
    x.opc = 6'($urandom);
    x.exp = e;
    return x;
  endfunction

  function automatic bit is_legal(input bit [5:0] o);
    bit [5:0] tbl [7] = '{6'd0, 6'd9, 6'd13, 6'd35, 6'd43, 6'd4, 6'd2};
    foreach (tbl[i]) if (tbl[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_rst(input int unsigned n, input bit rand_rdy);
    cyc_t x;
    for (int unsigned i = 0; i < n; i++) begin
      x = dc('0);
      x.rst = 1'b1;
      if (!rand_rdy) x.rdy = 1'b1;
      q.push_back(x);
    end
  endtask

  task automatic push_mem(inout cyc_t t[$], input logic [19:0] e, input int unsigned waits);
    cyc_t x;
    for (int unsigned i = 0; i <= waits; i++) begin
      x = dc(e);
      x.rdy = (i == waits);
      t.push_back(x);
    end
  endtask

  // keep < 0: whole instruction; 0: random abort point; > 0: abort after keep cycles.
  task automatic push_instr(input bit [5:0] opc, input int unsigned fw, input int unsigned mw,
                            input bit z, input int keep);
    cyc_t t[$];
    cyc_t x;
    int unsigned n;
    for (int unsigned i = 0; i < fw; i++) begin
      x = dc(ow(S_FETCH, 1,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 0,0,0,0));
      x.rdy = 1'b0;
      t.push_back(x);
    end
    x = dc(ow(S_FETCH, 1,0,0,1,1, 2'b00, 0, 2'b01, 2'b00, 0,0,0,0));
    x.rdy = 1'b1;
    t.push_back(x);
    x = dc(ow(S_DECODE, 0,0,0,0,0, 2'b00, 0, 2'b11, 2'b00, 0,0,0, !is_legal(opc)));
    x.opc = opc;
    t.push_back(x);
    case (opc)
      6'b000000: begin
        t.push_back(dc(ow(S_EXEC_R, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b10, 0,0,0,0)));
        t.push_back(dc(ow(S_WB_R,   0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,1,0,0)));
      end
      6'b001001, 6'b001101: begin
        t.push_back(dc(ow(S_EXEC_I, 0,0,0,0,0, 2'b00, 1, 2'b10,
                          (opc == 6'b001101) ? 2'b11 : 2'b00, 0,0,0,0)));
        t.push_back(dc(ow(S_WB_I,   0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,0,0)));
      end
      6'b100011: begin
        t.push_back(dc(ow(S_ADDR, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0)));
        push_mem(t, ow(S_MEM_RD, 1,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0), mw);
        t.push_back(dc(ow(S_WB_MEM, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,1,0)));
      end
      6'b101011: begin
        t.push_back(dc(ow(S_ADDR, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0)));
        push_mem(t, ow(S_MEM_WR, 1,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0), mw);
      end
      6'b000100: begin
        x = dc(ow(S_BRANCH, 0,0,0,0,z, 2'b01, 1, 2'b00, 2'b01, 0,0,0,0));
        x.z = z;
        t.push_back(x);
      end
      6'b000010: t.push_back(dc(ow(S_JUMP, 0,0,0,0,1, 2'b10, 0, 2'b00, 2'b00, 0,0,0,0)));
      default: ;
    endcase
    n = t.size();
    if (keep == 0 && t.size() > 1) n = $urandom_range(1, t.size() - 1);
    else if (keep > 0 && keep < int'(t.size())) n = keep;
    for (int unsigned i = 0; i < n; i++) q.push_back(t[i]);
    if (n < t.size()) push_rst(1, 1'b1);
  endtask

  task automatic chk_len(input string name, input int unsigned got, input int unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL len_%s: got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int unsigned n0;
    bit [5:0] ops [8] = '{6'd0, 6'd9, 6'd13, 6'd35, 6'd43, 6'd4, 6'd2, 6'd63};
    bit [5:0] o;
    logic [19:0] got;

    push_rst(3, 1'b0);
    n0 = q.size(); push_instr(6'b000000, 0, 0, 0, -1); chk_len("rtype", q.size() - n0, 4);
    n0 = q.size(); push_instr(6'b100011, 0, 3, 0, -1); chk_len("lw_w3", q.size() - n0, 8);
    n0 = q.size(); push_instr(6'b000100, 0, 0, 1, -1); chk_len("beq_t", q.size() - n0, 3);
    n0 = q.size(); push_instr(6'b000100, 0, 0, 0, -1); chk_len("beq_n", q.size() - n0, 3);
    n0 = q.size(); push_instr(6'b001101, 0, 0, 0, -1); chk_len("ori", q.size() - n0, 4);
    n0 = q.size(); push_instr(6'b111111, 0, 0, 0, -1); chk_len("illegal", q.size() - n0, 2);
    n0 = q.size(); push_instr(6'b101011, 0, 0, 0, -1); chk_len("sw", q.size() - n0, 4);
    n0 = q.size(); push_instr(6'b101011, 0, 3, 0, 4);  chk_len("sw_rst", q.size() - n0, 5);
    n0 = q.size(); push_instr(6'b000010, 0, 0, 0, -1); chk_len("j", q.size() - n0, 3);
    n0 = q.size(); push_instr(6'b001001, 2, 0, 0, -1); chk_len("addiu_fw2", q.size() - n0, 6);

    for (int i = 0; i < 150; i++) begin
      o = ops[$urandom_range(0, 7)];
      if (o == 6'd63) begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end
      push_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                 ($urandom_range(0, 9) == 0) ? 0 : -1);
    end

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst       = q[i].rst;
      mem_ready = q[i].rdy;
      zero      = q[i].z;
      opcode    = q[i].opc;
      #2;
      got = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             ALU_op, reg_write, reg_dst, mem_to_reg, illegal, state};
      total++;
      if (got !== q[i].exp) begin
        bad++;
        $display("FAIL ctrl_word cyc%0d rst=%0d: got=%h want=%h", i, q[i].rst, got, q[i].exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control FSM for the multi-cycle MIPS core. It sequences one shared ALU, the instruction/data memory port and the register file across FETCH/DECODE/EXEC/MEM/WB states. It emits the 2-bit `ALU_op` consumed by the existing ALU function decoder: 00 add, 01 sub, 10 R-type funct, 11 or. Memory accesses use a req/ready handshake, so the block tolerates wait states.

## Interface
- Parameters: none. Opcode, state and ALU_op constants come from `ctrl_pkg`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE.
- `zero`  in  1  ALU zero flag; sampled only in BRANCH.
- `mem_ready`  in  1  memory completion; meaningful only while `mem_req`=1.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe; valid with `mem_req`.
- `i_or_d`  out  1  memory address select: 0 PC, 1 ALUOut.
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  load PC.
- `pc_src`  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `alu_src_a`  out  1  ALU A operand: 0 PC, 1 rs.
- `alu_src_b`  out  2  ALU B operand: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- `ALU_op`  out  2  ALU operation code, encoding above.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  destination register: 0 rt, 1 rd.
- `mem_to_reg`  out  1  write-back source: 0 ALUOut, 1 MDR.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  4  current state, for debug and bench use.

## Operation
- Supported opcodes: R-type 000000, addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- Outputs are Moore-decoded from `state`, except `pc_write` in BRANCH (ANDed with `zero`) and `ir_write`/`pc_write` in FETCH (qualified by `mem_ready`).
- Unlisted outputs are 0 in every state.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ALU_op`=00.
  - Stays in FETCH while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `ALU_op`=00 (branch target). Latch `opcode` into an internal register, then dispatch:
  - R-type → EXEC_R; addiu/ori → EXEC_I; lw/sw → ADDR; beq → BRANCH; j → JUMP.
  - Any other opcode → `illegal`=1 for that cycle, then FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `ALU_op`=10 → WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1 → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `ALU_op`=00 for addiu or 11 for ori → WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0 → FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALU_op`=00 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_req`=1, `i_or_d`=1; hold until `mem_ready`, then → WB_MEM.
- WB_MEM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `i_or_d`=1; hold until `mem_ready`, then → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `ALU_op`=01, `pc_src`=01, `pc_write`=`zero` → FETCH.
- JUMP: `pc_write`=1, `pc_src`=10 → FETCH.

## Timing
- Reset: while `rst`=1, every output is forced to 0, including `mem_req`. On the first edge the state register loads FETCH, and `state` reads FETCH (0) from the first cycle after `rst` falls.
- `rst` asserted mid-instruction, including during a pending memory wait, aborts the instruction on the next edge. No register or PC write occurs in the cycle `rst` is high.
- Handshake:
  - `mem_req` stays high and `mem_we`/`i_or_d` stay stable until a cycle with `mem_ready`=1; the FSM advances on that edge.
  - `mem_ready` in the same cycle `mem_req` first rises is legal (zero-wait).
  - `mem_ready` while `mem_req`=0 is ignored.
- Cycle counts with zero-wait memory:
  - R-type, addiu, ori: 4.
  - lw: 5.
  - sw: 4.
  - beq, j: 3.
  - illegal: 2.
  - Each memory wait cycle adds 1.
- `opcode` may change after DECODE without effect.

## Structure
- `ctrl_pkg` holds:
  - the 4-bit state enum;
  - opcode localparams;
  - ALU_op localparams (ALU_ADD=00, ALU_SUB=01, ALU_RTYPE=10, ALU_OR=11);
  - pc_src and alu_src_b encodings.
- Split into two pieces:
  - the state register and next-state logic in `multi_cycle_ctrl`;
  - a combinational sub-module `multi_cycle_ctrl_decode` mapping {state, latched opcode} to the control word.

## Test plan
- Reset with `mem_ready`=1 → all outputs 0 during `rst`. FETCH then DECODE in the cycles after release, with `ir_write`=`pc_write`=1 in the first post-reset cycle.
- R-type, zero-wait → state trace FETCH, DECODE, EXEC_R, WB_R. `ALU_op`=10 in EXEC_R; `reg_write`=1 and `reg_dst`=1 in WB_R only.
- lw with 3 wait cycles on the data access → MEM_RD held 4 cycles with `mem_req`=1 and `i_or_d`=1. Then WB_MEM with `mem_to_reg`=1; 8 cycles total.
- beq run twice → `zero`=1 gives `pc_write`=1 with `pc_src`=01 in BRANCH; `zero`=0 gives `pc_write`=0. `ALU_op`=01 in both.
- ori then opcode 111111 → ori shows `ALU_op`=11 in EXEC_I. 111111 pulses `illegal` for exactly 1 cycle in DECODE, then returns to FETCH.
- `rst` pulsed during MEM_WR with `mem_ready`=0 → `mem_req` and `mem_we` drop in that cycle; FSM restarts in FETCH.
